// File: rtl/rmii_pkg.sv
// Shared constants and types for the RMII receive ring.
package rmii_pkg;

    localparam int RING_L  = 11;
    localparam int RING_SL = 2;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DISCARD,
        ST_POST
    } rmii_state_e;

    // Descriptor widths track the package geometry; the top-level defaults use the same values.
    typedef struct packed {
        logic [RING_SL-1:0]      slot;
        logic [RING_L-RING_SL:0] len;
        logic                    crc_ok;
    } desc_t;

endpackage

// File: rtl/crc32_byte.sv
// One byte step of the reflected CRC-32 (LSB of the byte first), no output inversion.
module crc32_byte
    import rmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Eight serial LFSR steps unrolled into one combinational stage.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/rmii_recv_ring.sv
// RMII receive-to-RAM writer with a ring of fixed-size frame slots and a descriptor queue.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for rx_busy to rise; claims the lowest free slot
// RECV     | writing bytes into the claimed slot, running the FCS check
// DISCARD  | frame is being dropped (no slot or oversize); wait for rx_busy low
// POST     | one cycle: push {slot, len, crc_ok} into the descriptor queue
module rmii_recv_ring
    import rmii_pkg::*;
#(
    parameter int L       = RING_L,
    parameter int SL      = RING_SL,
    parameter int MIN_LEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    input  logic          rx_busy,
    output logic [L-1:0]  addr,
    output logic [7:0]    wdata,
    output logic          we,
    output logic          desc_valid,
    input  logic          desc_ready,
    output logic [SL-1:0] desc_slot,
    output logic [L-SL:0] desc_len,
    output logic          desc_crc_ok,
    input  logic          rel_valid,
    input  logic [SL-1:0] rel_slot,
    output logic [SL:0]   free_cnt,
    output logic [15:0]   drop_cnt
);

    localparam int SLOTS = 1 << SL;
    localparam int SW    = L - SL;
    localparam logic [SW:0] S_LEN = {1'b1, {SW{1'b0}}};
    localparam logic [SW:0] MIN_L = (SW + 1)'(MIN_LEN);

    rmii_state_e state, state_nxt;

    logic             rx_busy_q;
    logic [SL-1:0]    slot_q;
    logic [SW:0]      len_q;
    logic [31:0]      crc_q, crc_nxt;
    logic [SLOTS-1:0] free_map, free_nxt;
    logic [SLOTS-1:0] queued_map, queued_nxt;

    desc_t            fifo_mem [SLOTS];
    desc_t            push_entry, desc_head;
    logic [SL-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [SL:0]      q_cnt, q_cnt_nxt;

    logic             busy_rise, any_free;
    logic [SL-1:0]    low_free;
    logic             claim, take_byte, give_back, drop_inc, push, pop, rel_ok;

    crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (rx_data),
        .crc_out (crc_nxt)
    );

    assign busy_rise = rx_busy & ~rx_busy_q;
    assign any_free  = |free_map;
    assign pop       = desc_valid & desc_ready;

    // Lowest-index free slot and number of free slots.
    always_comb begin
        low_free = '0;
        free_cnt = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                low_free = SL'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            free_cnt = free_cnt + (SL + 1)'(free_map[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        claim     = 1'b0;
        take_byte = 1'b0;
        give_back = 1'b0;
        drop_inc  = 1'b0;
        push      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (busy_rise) begin
                    if (any_free) begin
                        claim     = 1'b1;
                        state_nxt = ST_RECV;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_RECV: begin
                if (!rx_busy) begin
                    if (len_q == '0) begin
                        give_back = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (len_q < MIN_L) begin
                        give_back = 1'b1;
                        drop_inc  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_POST;
                    end
                end else if (rx_rdy) begin
                    if (len_q == S_LEN) begin
                        give_back = 1'b1;
                        drop_inc  = 1'b1;
                        state_nxt = ST_DISCARD;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (!rx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_POST: begin
                push      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: RAM write port, length, running CRC, drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_busy_q <= 1'b1;
            slot_q    <= '0;
            len_q     <= '0;
            crc_q     <= CRC_INIT;
            addr      <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            rx_busy_q <= rx_busy;
            we        <= take_byte;
            if (take_byte) begin
                addr  <= {slot_q, len_q[SW-1:0]};
                wdata <= rx_data;
                len_q <= len_q + 1'b1;
                crc_q <= crc_nxt;
            end
            if (claim) begin
                slot_q <= low_free;
                len_q  <= '0;
                crc_q  <= CRC_INIT;
            end
            if (drop_inc && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // A slot may be released only while owned, not queued and not the one being filled.
    assign rel_ok = rel_valid & ~free_map[rel_slot] & ~queued_map[rel_slot]
                  & ~(((state == ST_RECV) || (state == ST_POST)) && (slot_q == rel_slot));

    // Next free/queued bitmaps; allocation uses the bitmap before any same-cycle release.
    always_comb begin
        free_nxt   = free_map;
        queued_nxt = queued_map;
        if (rel_ok) begin
            free_nxt[rel_slot] = 1'b1;
        end
        if (give_back) begin
            free_nxt[slot_q] = 1'b1;
        end
        if (claim) begin
            free_nxt[low_free] = 1'b0;
        end
        if (push) begin
            queued_nxt[slot_q] = 1'b1;
        end
        if (pop) begin
            queued_nxt[desc_head.slot] = 1'b0;
        end
    end

    // Slot ownership bitmaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_map   <= '1;
            queued_map <= '0;
        end else begin
            free_map   <= free_nxt;
            queued_map <= queued_nxt;
        end
    end

    assign push_entry = '{slot: slot_q, len: len_q, crc_ok: (crc_q == CRC_RESIDUE)};
    assign q_cnt_nxt  = q_cnt + (SL + 1)'(push) - (SL + 1)'(pop);
    assign rd_ptr_nxt = rd_ptr + SL'(pop);

    // Descriptor storage; entries need no reset since q_cnt gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // Queue pointers and registered head; the head bypasses a push landing on the new read slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_cnt      <= '0;
            desc_valid <= 1'b0;
            desc_head  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr_nxt;
            q_cnt      <= q_cnt_nxt;
            desc_valid <= (q_cnt_nxt != '0);
            if (push && (wr_ptr == rd_ptr_nxt)) begin
                desc_head <= push_entry;
            end else begin
                desc_head <= fifo_mem[rd_ptr_nxt];
            end
        end
    end

    assign desc_slot   = desc_head.slot;
    assign desc_len    = desc_head.len;
    assign desc_crc_ok = desc_head.crc_ok;

endmodule
